// File: rtl/proc_seq_pkg.sv
// Shared definitions for the proc instruction sequencer: FSM states,
// opcodes and instruction field positions.
package proc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT,
        S_ERR
    } seq_state_t;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;

    localparam int unsigned OPC_HI = 8;
    localparam int unsigned OPC_LO = 6;
    localparam int unsigned RX_HI  = 5;
    localparam int unsigned RX_LO  = 3;
    localparam int unsigned RY_HI  = 2;
    localparam int unsigned RY_LO  = 0;

endpackage

// File: rtl/seq_watchdog.sv
// Done watchdog: counts enabled cycles since clear and flags the cycle
// in which the TIMEOUT-th enabled cycle is being spent.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expired is combinational so the FSM leaves on the edge ending that cycle
    assign expired = en && (count >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !expired)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/proc_sequencer.sv
// Fetches instructions from a synchronous ROM and feeds them to proc with
// a one-cycle Run pulse, supplying mvi immediates and waiting for Done.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned LAST_ADDR = 31,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Step,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [7:0]        InstrCount
);

    seq_state_t state, state_nxt;

    logic [ADDR_W-1:0] pc;
    logic              opc_mvi;
    logic              complete;
    logic              restart;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;
    logic [ADDR_W:0]   last_addr;
    seq_state_t        done_target;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (Clock),
        .rst    (Reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    // Halt test uses one extra bit so an mvi at the top address is not wrapped
    assign last_addr = {1'b0, pc} + {{ADDR_W{1'b0}}, opc_mvi};

    always_comb begin
        if (last_addr >= (ADDR_W + 1)'(LAST_ADDR))
            done_target = S_HALT;
        else if (Step)
            done_target = S_IDLE;
        else
            done_target = S_FETCH;
    end

    always_comb begin
        state_nxt = state;
        MemAddr   = pc;
        DIN       = '0;
        Run       = 1'b0;
        complete  = 1'b0;
        restart   = 1'b0;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start)
                    state_nxt = S_FETCH;
            end
            S_HALT, S_ERR: begin
                if (Start) begin
                    restart   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: begin
                DIN     = MemData;
                Run     = 1'b1;
                MemAddr = pc + 1'b1;
                wd_clr  = 1'b1;
                if (MemData[OPC_HI:OPC_LO] == OPC_MVI)
                    state_nxt = S_IMM;
                else
                    state_nxt = S_WAIT;
            end
            S_IMM: begin
                DIN   = MemData;
                wd_en = 1'b1;
                if (Done) begin
                    complete  = 1'b1;
                    state_nxt = done_target;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_en = 1'b1;
                if (Done) begin
                    complete  = 1'b1;
                    state_nxt = done_target;
                end else if (wd_expired) begin
                    state_nxt = S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Busy   = (state == S_FETCH) || (state == S_ISSUE) ||
                    (state == S_IMM)   || (state == S_WAIT);
    assign Halted = (state == S_HALT);
    assign Error  = (state == S_ERR);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            InstrCount <= '0;
            opc_mvi    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_ISSUE)
                opc_mvi <= (MemData[OPC_HI:OPC_LO] == OPC_MVI);
            if (restart) begin
                pc         <= '0;
                InstrCount <= '0;
            end else if (complete) begin
                pc         <= pc + (opc_mvi ? ADDR_W'(2) : ADDR_W'(1));
                InstrCount <= InstrCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: a small-program instance (LAST_ADDR=1)
// and a full-ROM instance exercising address wrap of an mvi immediate.
module tb_proc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start_a = 1'b0, step_a = 1'b0, done_force = 1'b0;
    logic [4:0] mem_addr_a;
    logic [8:0] mem_data_a, din_a;
    logic       run_a, done_a, busy_a, halted_a, error_a;
    logic [7:0] icount_a;

    logic       start_b = 1'b0;
    logic [4:0] mem_addr_b;
    logic [8:0] mem_data_b, din_b;
    logic       run_b, done_b, busy_b, halted_b, error_b;
    logic [7:0] icount_b;

    logic [8:0] rom_a [32];
    logic [8:0] rom_b [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    proc_sequencer #(.ADDR_W(5), .DATA_W(9), .LAST_ADDR(1), .TIMEOUT(15)) dut_a (
        .Clock(clk), .Reset(rst), .Start(start_a), .Step(step_a),
        .MemAddr(mem_addr_a), .MemData(mem_data_a), .DIN(din_a), .Run(run_a),
        .Done(done_a), .Busy(busy_a), .Halted(halted_a), .Error(error_a),
        .InstrCount(icount_a)
    );

    proc_sequencer #(.ADDR_W(5), .DATA_W(9), .LAST_ADDR(31), .TIMEOUT(15)) dut_b (
        .Clock(clk), .Reset(rst), .Start(start_b), .Step(1'b0),
        .MemAddr(mem_addr_b), .MemData(mem_data_b), .DIN(din_b), .Run(run_b),
        .Done(done_b), .Busy(busy_b), .Halted(halted_b), .Error(error_b),
        .InstrCount(icount_b)
    );

    always @(posedge clk) begin
        mem_data_a <= rom_a[mem_addr_a];
        mem_data_b <= rom_b[mem_addr_b];
    end

    // proc model A: Done done_dly cycles after Run (0 = never)
    int unsigned done_dly = 1;
    int unsigned dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst)              dcnt <= 0;
        else if (run_a)       dcnt <= done_dly;
        else if (dcnt != 0)   dcnt <= dcnt - 1;
    end
    assign done_a = (dcnt == 1) || done_force;

    // proc model B: Done the cycle after Run
    logic run_b_q;
    always @(posedge clk or posedge rst) begin
        if (rst) run_b_q <= 1'b0;
        else     run_b_q <= run_b;
    end
    assign done_b = run_b_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         nrun, done_cyc1, err_cyc;
    int         run_cyc [4];
    logic [8:0] run_din [4];

    // Raise Start for one cycle and observe ncyc cycles of instance A
    task automatic run_prog(input int ncyc, input bit busy_start);
        nrun = 0; done_cyc1 = -1; err_cyc = -1;
        for (int i = 0; i < 4; i++) begin run_cyc[i] = -1; run_din[i] = '0; end
        start_a = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            start_a = busy_start && (k < 4);
            if (run_a) begin
                if (nrun < 4) begin run_cyc[nrun] = k; run_din[nrun] = din_a; end
                nrun++;
            end
            if (done_a && done_cyc1 < 0) done_cyc1 = k;
            if (error_a && err_cyc < 0)  err_cyc = k;
        end
        start_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit saw_mvi;
        for (int i = 0; i < 32; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
        rom_a[0] = 9'h040; rom_a[1] = 9'd5;
        rom_b[0] = 9'h008; rom_b[31] = 9'h040;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {busy_a, halted_a, error_a, run_a, din_a, mem_addr_a, icount_a}, '0);

        // mvi then halt
        done_dly = 1;
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("t1_fetch_run", run_a, 1'b0);
        check("t1_fetch_busy", busy_a, 1'b1);
        @(negedge clk);
        check("t1_issue_run", run_a, 1'b1);
        check("t1_issue_din", din_a, 9'h040);
        check("t1_issue_addr", mem_addr_a, 5'd1);
        @(negedge clk);
        check("t1_imm_din", din_a, 9'd5);
        check("t1_imm_run", run_a, 1'b0);
        @(negedge clk);
        check("t1_halt", {halted_a, busy_a, icount_a}, {1'b1, 1'b0, 8'd1});

        // wrap-around on instance B: mvi at 31 takes immediate from address 0
        saw_mvi = 0;
        start_b = 1'b1;
        for (int k = 0; k < 200 && !halted_b; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (run_b && din_b == 9'h040 && !saw_mvi) begin
                saw_mvi = 1;
                check("t5_issue_addr", mem_addr_b, 5'd0);
                @(negedge clk);
                check("t5_imm_din", din_b, 9'h008);
            end
        end
        check("t5_saw_mvi", saw_mvi, 1'b1);
        check("t5_halt", {halted_b, icount_b}, {1'b1, 8'd32});

        // free run
        rom_a[0] = 9'h08A; rom_a[1] = 9'h011; done_dly = 3;
        run_prog(20, 0);
        check("t2_nrun", nrun, 2);
        check("t2_start_to_run", run_cyc[0], 1);
        check("t2_din0", run_din[0], 9'h08A);
        check("t2_din1", run_din[1], 9'h011);
        check("t2_done_to_run", run_cyc[1] - done_cyc1, 2);
        check("t2_halt", {halted_a, icount_a}, {1'b1, 8'd2});

        // single step
        step_a = 1'b1;
        run_prog(20, 0);
        check("t3_nrun", nrun, 1);
        check("t3_idle", {busy_a, halted_a, mem_addr_a, icount_a}, {1'b0, 1'b0, 5'd1, 8'd1});
        run_prog(20, 0);
        check("t3_din", run_din[0], 9'h011);
        check("t3_halt", {halted_a, icount_a}, {1'b1, 8'd2});

        // watchdog: advance to address 1, then withhold Done
        run_prog(20, 0);
        step_a = 1'b0; done_dly = 0;
        run_prog(30, 0);
        check("t4_nrun", nrun, 1);
        check("t4_din", run_din[0], 9'h011);
        check("t4_err_latency", err_cyc - run_cyc[0], 16);
        check("t4_err", {error_a, busy_a, icount_a}, {1'b1, 1'b0, 8'd1});
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("t4_restart", {mem_addr_a, icount_a, error_a, busy_a}, {5'd0, 8'd0, 1'b0, 1'b1});
        repeat (20) @(negedge clk);
        check("t4_err_again", error_a, 1'b1);

        // asynchronous reset while waiting with PC and count nonzero
        done_dly = 3; step_a = 1'b1;
        run_prog(20, 0);
        done_dly = 0; step_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_wait_state", {busy_a, mem_addr_a, icount_a}, {1'b1, 5'd1, 8'd1});
        #2 rst = 1'b1;
        #1 check("t6_async_reset", {busy_a, halted_a, error_a, run_a, din_a, mem_addr_a, icount_a}, '0);
        @(negedge clk); rst = 1'b0;

        // spurious Done in IDLE, Start while Busy
        done_force = 1'b1;
        @(negedge clk); done_force = 1'b0;
        @(negedge clk);
        check("t6_done_idle", {busy_a, halted_a, mem_addr_a, icount_a}, '0);
        done_dly = 3;
        run_prog(20, 1);
        check("t6_busy_start_nrun", nrun, 2);
        check("t6_busy_start_halt", {halted_a, icount_a}, {1'b1, 8'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Instruction sequencer for the 9-bit `proc` datapath. It fetches instruction words from a synchronous program ROM and presents each one on `DIN` with a one-cycle `Run` pulse. For `mvi` it supplies the immediate word on the following cycle. It then waits for `Done` before issuing the next instruction. It adds run, single-step, halt-at-end and a `Done` watchdog, and sits between the program ROM and `proc`.

## Interface

Parameters:
- `ADDR_W`, default 5: ROM address width.
- `DATA_W`, default 9: instruction/data width. Must match `proc`.
- `LAST_ADDR`, default 31: highest program address. Execution halts once it is consumed.
- `TIMEOUT`, default 15: maximum wait, in cycles after issue, for `Done`.

Ports:
- `Clock`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `Start`, in, 1: level sampled per cycle. Begins, resumes or restarts execution.
- `Step`, in, 1: single-step mode. Sampled at instruction completion.
- `MemAddr`, out, `ADDR_W`: ROM address.
- `MemData`, in, `DATA_W`: ROM data, valid the cycle after `MemAddr`.
- `DIN`, out, `DATA_W`: to `proc.DIN`.
- `Run`, out, 1: to `proc.Run`.
- `Done`, in, 1: from `proc.Done`.
- `Busy`, out, 1: an instruction is in flight.
- `Halted`, out, 1: program end reached.
- `Error`, out, 1: watchdog expired.
- `InstrCount`, out, 8: completed instructions, modulo 256.

## Operation

States:
- `IDLE`
- `FETCH`
- `ISSUE`
- `IMM`
- `WAIT`
- `HALT`
- `ERR`

Transitions:
- **`IDLE`**: `Start` → `FETCH`. `PC` is kept, so execution resumes.
- **`HALT`, `ERR`**: `Start` → `FETCH`. `PC`, `InstrCount` and flags are cleared first.
- **`FETCH`**:
  - `MemAddr`=`PC`.
  - → `ISSUE`.
- **`ISSUE`**:
  - `DIN`=`MemData`, `Run`=1, `MemAddr`=`PC`+1 (mod 2^`ADDR_W`).
  - Latch opcode `MemData[8:6]`. Clear the watchdog.
  - Opcode `MVI` → `IMM`. Otherwise → `WAIT`.
- **`IMM`**:
  - `DIN`=`MemData`, which is the immediate.
  - `Done` → complete. Otherwise → `WAIT`.
- **`WAIT`**:
  - `DIN`=0.
  - `Done` → complete.
  - Watchdog reaching `TIMEOUT` without `Done` → `ERR`.

Completion:
- `PC` += 1, or += 2 for `mvi`.
- `InstrCount` += 1.
- If the completed instruction's last word address is ≥ `LAST_ADDR` (computed in `ADDR_W`+1 bits) → `HALT`.
- Else if `Step` → `IDLE`.
- Else → `FETCH`.

Output rules:
- `Busy`=1 in `FETCH`/`ISSUE`/`IMM`/`WAIT`.
- `Halted`=1 only in `HALT`. `Error`=1 only in `ERR`.
- `DIN`=0 and `Run`=0 outside `ISSUE`/`IMM`.
- `MemAddr` is `PC` outside `ISSUE`.

Boundary conditions:
- `Done` in `IDLE`/`FETCH`/`ISSUE`/`HALT`/`ERR` is ignored.
- `Start` while `Busy` is ignored.
- A `mvi` at address 2^`ADDR_W`−1 reads its immediate from address 0. Halt is evaluated on the unwrapped address.
- `InstrCount` wraps 255→0.
- `Step` and `Start` both high at completion → `IDLE`. The next cycle then starts (`IDLE`+`Start` → `FETCH`).

Reset, at any time: state `IDLE`, `PC`=0, `InstrCount`=0, `Run`=0, `DIN`=0, `MemAddr`=0, `Busy`/`Halted`/`Error`=0.

## Timing

- `Start` to `Run`: 2 cycles (`IDLE`→`FETCH`→`ISSUE`).
- `Run` is high for exactly one cycle per instruction.
- The immediate is on `DIN` in the cycle immediately after `Run`. This is the `proc` contract.
- Earliest `Done` is the cycle after `Run`, which covers `mv`/`mvi`.
- `Done` to next `Run`: 2 cycles in free-run mode.
- Watchdog:
  - Counter is 0 in `ISSUE` and counts each `IMM`/`WAIT` cycle.
  - `ERR` is entered on the edge ending the `TIMEOUT`th wait cycle.
  - `Done` in that same cycle wins.
- `Run`, `DIN`, `Busy`, `MemAddr`: combinational from state and `PC`. `Halted`, `Error`: decoded from state. `DIN` passes `MemData` through combinationally.

## Structure

- Package `proc_seq_pkg`:
  - State encoding.
  - Opcode constants `OPC_MV`=3'b000, `OPC_MVI`=3'b001, `OPC_ADD`=3'b010, `OPC_SUB`=3'b011.
  - Field positions: opcode [8:6], X [5:3], Y [2:0].
- Sub-module `seq_watchdog`: clear/enable counter with an `expired` output, parameterised by `TIMEOUT`.
- Everything else lives in `proc_sequencer`: FSM, `PC`, `InstrCount`.

## Test plan

1. **`mvi` then halt.** `LAST_ADDR`=1, ROM[0]=9'h040 (`mvi R0`), ROM[1]=9'd5, `proc` model asserts `Done` on the cycle after `Run`. Pulse `Start` → `Run`=1 with `DIN`=9'h040 two cycles later; next cycle `DIN`=5; then `Halted`=1, `InstrCount`=1, `Busy`=0.
2. **Free run.** ROM[0]=`add` 9'h08A, `Done` delayed 3 cycles after `Run`; ROM[1]=`mv` 9'h011, `LAST_ADDR`=1. → Second `Run` occurs 2 cycles after the first `Done`; `Halted` with `InstrCount`=2.
3. **Single step.** `Step`=1 over the same ROM. → After the first `Done`, return to `IDLE` with `Busy`=0 and `MemAddr`=1. A second `Start` issues 9'h011.
4. **Watchdog.** `Done` withheld, `TIMEOUT`=15. → `Error`=1 after 15 wait cycles, with no further `Run`. `Start` then restarts at address 0 with `InstrCount`=0.
5. **Wrap-around.** `ADDR_W`=5, `LAST_ADDR`=31, `mvi` at address 31. → Immediate read from address 0 (`MemAddr`=0 during `ISSUE`); `HALT` after completion.
6. **Reset and spurious inputs.** Assert `Reset` in `WAIT` → all outputs 0 immediately, without a clock. `Done` pulses in `IDLE`, and `Start` pulses while `Busy`, → no state or `InstrCount` change.
